// File: rtl/layer_sequencer.sv
// layer_sequencer: top-level phase sequencer for the MobileNet inference datapath.
// Walks camera capture, a conv0 phase (one feature fetch, then conv + write-back
// per op), a conv1 phase (fetch + conv + write-back per op) and an average phase
// (fetch + average per op). Each engine gets a one-cycle start strobe, and the
// sequencer waits for that engine's finish pulse with a timeout.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 host start level (sampled in IDLE / ERROR)
//   i_continuous            restart at camera after the last average op
//   i_abort                 return to IDLE next cycle from any state
//   i_finish_*              engine completion pulses
//   o_start*                one-cycle engine start strobes
//   o_opConv, o_opcode      conv1-phase flag and current operation index
//   o_phase                 0=conv0, 1=conv1, 2=ave, 3=idle/cam/error
//   o_busy, o_done, o_error status, frame-done pulse, sticky timeout flag
module layer_sequencer #(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned N_CONV0     = 16,
   parameter int unsigned N_CONV1     = 16,
   parameter int unsigned N_AVE       = 6,
   parameter int unsigned TIMEOUT_W   = 20,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_continuous,
   input  logic                i_abort,
   input  logic                i_finish_cam,
   input  logic                i_finish_fet,
   input  logic                i_finish_conv,
   input  logic                i_finish_writeBack,
   input  logic                i_finish_ave,
   output logic                o_startCam,
   output logic                o_startFet,
   output logic                o_startConvolution,
   output logic                o_startWriteBack,
   output logic                o_startAve,
   output logic                o_opConv,
   output logic [OPCODE_W-1:0] o_opcode,
   output logic [1:0]          o_phase,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_error
);

   localparam int unsigned TOTAL = N_CONV0 + N_CONV1 + N_AVE;
   localparam logic [OPCODE_W-1:0]  LAST_C0  = OPCODE_W'(N_CONV0 - 1);
   localparam logic [OPCODE_W-1:0]  LAST_C1  = OPCODE_W'(N_CONV0 + N_CONV1 - 1);
   localparam logic [OPCODE_W-1:0]  LAST_ALL = OPCODE_W'(TOTAL - 1);
   localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [4:0] {
      S_IDLE, S_CAM, S_W_CAM,
      S_FET0, S_W_FET0, S_CONV0, S_W_CONV0, S_WB0, S_W_WB0, S_UPD0,
      S_FET1, S_W_FET1, S_CONV1, S_W_CONV1, S_WB1, S_W_WB1, S_UPD1,
      S_FETA, S_W_FETA, S_AVE, S_W_AVE, S_UPD_AVE,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [OPCODE_W-1:0]   opcode_q, opcode_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  error_q, error_d;
   logic                  start_cam_q, start_cam_d;
   logic                  start_fet_q, start_fet_d;
   logic                  start_conv_q, start_conv_d;
   logic                  start_wb_q, start_wb_d;
   logic                  start_ave_q, start_ave_d;
   logic                  op_conv_q, op_conv_d;
   logic [1:0]            phase_q, phase_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  in_wait;
   logic                  fin_sel;
   state_t                wait_next;

   // Next-state / opcode / timeout logic, then outputs decoded from the next state
   // so the registered outputs line up with the registered state.
   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      cnt_d     = '0;
      error_d   = error_q;
      in_wait   = 1'b1;
      fin_sel   = 1'b0;
      wait_next = state_q;

      // Finish input and successor for each wait state
      case (state_q)
         S_W_CAM:   begin fin_sel = i_finish_cam;       wait_next = S_FET0;    end
         S_W_FET0:  begin fin_sel = i_finish_fet;       wait_next = S_CONV0;   end
         S_W_CONV0: begin fin_sel = i_finish_conv;      wait_next = S_WB0;     end
         S_W_WB0:   begin fin_sel = i_finish_writeBack; wait_next = S_UPD0;    end
         S_W_FET1:  begin fin_sel = i_finish_fet;       wait_next = S_CONV1;   end
         S_W_CONV1: begin fin_sel = i_finish_conv;      wait_next = S_WB1;     end
         S_W_WB1:   begin fin_sel = i_finish_writeBack; wait_next = S_UPD1;    end
         S_W_FETA:  begin fin_sel = i_finish_fet;       wait_next = S_AVE;     end
         S_W_AVE:   begin fin_sel = i_finish_ave;       wait_next = S_UPD_AVE; end
         default:   in_wait = 1'b0;
      endcase

      case (state_q)
         S_IDLE: begin
            opcode_d = '0;
            if (i_start) state_d = S_CAM;
         end
         S_CAM:   state_d = S_W_CAM;
         S_FET0:  state_d = S_W_FET0;
         S_CONV0: state_d = S_W_CONV0;
         S_WB0:   state_d = S_W_WB0;
         S_UPD0: begin
            opcode_d = opcode_q + OPCODE_W'(1);
            state_d  = (opcode_q == LAST_C0) ? S_FET1 : S_CONV0;
         end
         S_FET1:  state_d = S_W_FET1;
         S_CONV1: state_d = S_W_CONV1;
         S_WB1:   state_d = S_W_WB1;
         S_UPD1: begin
            opcode_d = opcode_q + OPCODE_W'(1);
            state_d  = (opcode_q == LAST_C1) ? S_FETA : S_FET1;
         end
         S_FETA:  state_d = S_W_FETA;
         S_AVE:   state_d = S_W_AVE;
         S_UPD_AVE: begin
            if (opcode_q == LAST_ALL) begin
               opcode_d = '0;
               state_d  = i_continuous ? S_CAM : S_IDLE;
            end else begin
               opcode_d = opcode_q + OPCODE_W'(1);
               state_d  = S_FETA;
            end
         end
         S_ERROR: begin
            if (i_start) begin
               state_d  = S_CAM;
               opcode_d = '0;
               error_d  = 1'b0;
            end
         end
         default: begin
            // Wait states: a finish in the last allowed cycle still wins over the timeout
            if (in_wait) begin
               if (fin_sel) begin
                  state_d = wait_next;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + TIMEOUT_W'(1);
               end
            end
         end
      endcase

      // Abort overrides every transition but leaves the sticky error alone
      if (i_abort) begin
         state_d  = S_IDLE;
         opcode_d = '0;
         cnt_d    = '0;
         error_d  = error_q;
      end

      start_cam_d  = (state_d == S_CAM);
      start_fet_d  = (state_d == S_FET0) || (state_d == S_FET1) || (state_d == S_FETA);
      start_conv_d = (state_d == S_CONV0) || (state_d == S_CONV1);
      start_wb_d   = (state_d == S_WB0) || (state_d == S_WB1);
      start_ave_d  = (state_d == S_AVE);
      busy_d       = (state_d != S_IDLE) && (state_d != S_ERROR);
      done_d       = (state_d == S_UPD_AVE) && (opcode_d == LAST_ALL);

      case (state_d)
         S_FET0, S_W_FET0, S_CONV0, S_W_CONV0, S_WB0, S_W_WB0, S_UPD0:
            phase_d = 2'd0;
         S_FET1, S_W_FET1, S_CONV1, S_W_CONV1, S_WB1, S_W_WB1, S_UPD1:
            phase_d = 2'd1;
         S_FETA, S_W_FETA, S_AVE, S_W_AVE, S_UPD_AVE:
            phase_d = 2'd2;
         default:
            phase_d = 2'd3;
      endcase
      op_conv_d = (phase_d == 2'd1);
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         opcode_q     <= '0;
         cnt_q        <= '0;
         error_q      <= 1'b0;
         start_cam_q  <= 1'b0;
         start_fet_q  <= 1'b0;
         start_conv_q <= 1'b0;
         start_wb_q   <= 1'b0;
         start_ave_q  <= 1'b0;
         op_conv_q    <= 1'b0;
         phase_q      <= 2'd3;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         cnt_q        <= cnt_d;
         error_q      <= error_d;
         start_cam_q  <= start_cam_d;
         start_fet_q  <= start_fet_d;
         start_conv_q <= start_conv_d;
         start_wb_q   <= start_wb_d;
         start_ave_q  <= start_ave_d;
         op_conv_q    <= op_conv_d;
         phase_q      <= phase_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign o_startCam         = start_cam_q;
   assign o_startFet         = start_fet_q;
   assign o_startConvolution = start_conv_q;
   assign o_startWriteBack   = start_wb_q;
   assign o_startAve         = start_ave_q;
   assign o_opConv           = op_conv_q;
   assign o_opcode           = opcode_q;
   assign o_phase            = phase_q;
   assign o_busy             = busy_q;
   assign o_done             = done_q;
   assign o_error            = error_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer with small phase counts.
// A frame model pushes the expected strobe/done events; a monitor pops and compares
// each event the DUT presents; a responder process answers strobes after random delays.
module tb_layer_sequencer;
   localparam int OW    = 4;
   localparam int N0    = 4;
   localparam int N1    = 3;
   localparam int NA    = 2;
   localparam int TW    = 5;
   localparam int TO    = 12;
   localparam int TOTAL = N0 + N1 + NA;

   localparam int K_CAM  = 0;
   localparam int K_FET  = 1;
   localparam int K_CONV = 2;
   localparam int K_WB   = 3;
   localparam int K_AVE  = 4;
   localparam int K_DONE = 5;

   logic clk = 1'b0;
   logic i_reset = 1'b1, i_start = 1'b0, i_continuous = 1'b0, i_abort = 1'b0;
   logic i_finish_cam = 1'b0, i_finish_fet = 1'b0, i_finish_conv = 1'b0;
   logic i_finish_writeBack = 1'b0, i_finish_ave = 1'b0;
   logic o_startCam, o_startFet, o_startConvolution, o_startWriteBack, o_startAve;
   logic o_opConv, o_busy, o_done, o_error;
   logic [OW-1:0] o_opcode;
   logic [1:0]    o_phase;

   typedef struct {
      int kind;
      int op;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  stray_op  = -1;
   int  hold_kind = -1;
   int  hold_op   = -1;

   always #5 clk = ~clk;

   layer_sequencer #(
      .OPCODE_W(OW), .N_CONV0(N0), .N_CONV1(N1), .N_AVE(NA),
      .TIMEOUT_W(TW), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_continuous(i_continuous),
      .i_abort(i_abort), .i_finish_cam(i_finish_cam), .i_finish_fet(i_finish_fet),
      .i_finish_conv(i_finish_conv), .i_finish_writeBack(i_finish_writeBack),
      .i_finish_ave(i_finish_ave), .o_startCam(o_startCam), .o_startFet(o_startFet),
      .o_startConvolution(o_startConvolution), .o_startWriteBack(o_startWriteBack),
      .o_startAve(o_startAve), .o_opConv(o_opConv), .o_opcode(o_opcode),
      .o_phase(o_phase), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference phase of an operation index: conv0 ops first, then conv1, then average
   function automatic int phase_of(input int kind, input int op);
      if (kind == K_CAM) return 3;
      if (op < N0) return 0;
      if (op < N0 + N1) return 1;
      return 2;
   endfunction

   task automatic push(input int kind, input int op);
      ev_t e;
      e.kind = kind;
      e.op   = op;
      exp_q.push_back(e);
   endtask

   // One full frame of expected events
   task automatic push_frame();
      push(K_CAM, 0);
      push(K_FET, 0);
      for (int op = 0; op < N0; op++) begin
         push(K_CONV, op);
         push(K_WB, op);
      end
      for (int op = N0; op < N0 + N1; op++) begin
         push(K_FET, op);
         push(K_CONV, op);
         push(K_WB, op);
      end
      for (int op = N0 + N1; op < TOTAL; op++) begin
         push(K_FET, op);
         push(K_AVE, op);
      end
      push(K_DONE, TOTAL - 1);
   endtask

   function automatic int cur_kind();
      if (o_startCam) return K_CAM;
      if (o_startFet) return K_FET;
      if (o_startConvolution) return K_CONV;
      if (o_startWriteBack) return K_WB;
      if (o_startAve) return K_AVE;
      if (o_done) return K_DONE;
      return -1;
   endfunction

   task automatic set_fin(input int kind, input logic v);
      case (kind)
         K_CAM:   i_finish_cam       = v;
         K_FET:   i_finish_fet       = v;
         K_CONV:  i_finish_conv      = v;
         K_WB:    i_finish_writeBack = v;
         default: i_finish_ave       = v;
      endcase
   endtask

   // Monitor: every presented event is compared against the scoreboard head
   always @(negedge clk) begin
      int  nev;
      int  k;
      ev_t e;
      nev = int'(o_startCam) + int'(o_startFet) + int'(o_startConvolution) +
            int'(o_startWriteBack) + int'(o_startAve) + int'(o_done);
      if (nev > 1) begin
         check("single_event", nev, 1);
      end else if (nev == 1) begin
         k = cur_kind();
         if (exp_q.size() == 0) begin
            check("unexpected_event_kind", k, -1);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_opcode", int'(o_opcode), e.op);
            check("event_phase", int'(o_phase), phase_of(e.kind, e.op));
            check("event_opconv", int'(o_opConv), int'(phase_of(e.kind, e.op) == 1));
         end
      end
   end

   // Engine responder: finish pulse a random 1..5 cycles after each strobe
   initial begin : responder
      int k, op, d;
      bit early;
      forever begin
         @(negedge clk);
         k  = cur_kind();
         op = int'(o_opcode);
         if (k >= K_CAM && k <= K_AVE) begin
            if (k == K_FET && op == stray_op) begin
               set_fin(K_FET, 1'b1);
               @(posedge clk); #1 set_fin(K_FET, 1'b0);
               early = 1'b0;
               repeat (4) begin
                  @(negedge clk);
                  if (o_startConvolution) early = 1'b1;
               end
               check("stray_fet_ignored", int'(early), 0);
               check("stray_still_busy", int'(o_busy), 1);
               set_fin(K_FET, 1'b1);
               @(posedge clk); #1 set_fin(K_FET, 1'b0);
            end else if (!(k == hold_kind && op == hold_op)) begin
               d = int'($urandom_range(5, 1));
               repeat (d) @(posedge clk);
               #1 set_fin(k, 1'b1);
               @(posedge clk); #1 set_fin(k, 1'b0);
            end
         end
      end
   end

   task automatic wait_ev(input string name, input int kind, input int op, input int limit);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(negedge clk);
         if (cur_kind() == kind && (op < 0 || int'(o_opcode) == op)) seen = 1'b1;
      end
      if (!seen) check({name, "_wait_expired"}, 0, 1);
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"}, int'(o_busy), 0);
      check({name, "_phase"}, int'(o_phase), 3);
      check({name, "_opcode"}, int'(o_opcode), 0);
      check({name, "_error"}, int'(o_error), 0);
      check({name, "_strobes"}, int'({o_startCam, o_startFet, o_startConvolution,
                                      o_startWriteBack, o_startAve, o_done, o_opConv}), 0);
   endtask

   task automatic start_pulse();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
   endtask

   initial begin : main
      int  got;
      bit  seen;
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      @(negedge clk);
      check_idle("reset");

      // Single frame
      push_frame();
      start_pulse();
      wait_ev("frame1_done", K_DONE, -1, 2000);
      @(negedge clk);
      check_idle("frame1_end");
      check("frame1_queue_empty", exp_q.size(), 0);

      // Continuous restart, then start held high in IDLE, then plain finish
      push_frame(); push_frame(); push_frame();
      i_continuous = 1'b1;
      start_pulse();
      wait_ev("cont1_done", K_DONE, -1, 2000);
      @(negedge clk);
      check("cont_cam_after_done", int'(o_startCam), 1);
      check("cont_cam_opcode", int'(o_opcode), 0);
      check("cont_busy", int'(o_busy), 1);
      i_continuous = 1'b0;
      i_start = 1'b1;
      wait_ev("cont2_done", K_DONE, -1, 2000);
      @(negedge clk);
      check("held_start_idle_busy", int'(o_busy), 0);
      @(negedge clk);
      check("held_start_restart_cam", int'(o_startCam), 1);
      i_start = 1'b0;
      wait_ev("cont3_done", K_DONE, -1, 2000);
      @(negedge clk);
      check_idle("cont_end");
      check("cont_queue_empty", exp_q.size(), 0);

      // Stray fetch finish in the first conv1 fetch strobe, then abort mid conv1
      stray_op = N0;
      push_frame();
      start_pulse();
      wait_ev("abort_point", K_CONV, N0 + 1, 2000);
      i_abort = 1'b1;
      @(posedge clk); #1 i_abort = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle("abort");
      repeat (10) @(negedge clk);
      stray_op = -1;

      // Timeout on a withheld conv finish, then restart from ERROR
      hold_kind = K_CONV;
      hold_op   = 2;
      push_frame();
      start_pulse();
      wait_ev("timeout_point", K_CONV, 2, 2000);
      got  = -1;
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (o_error) begin
            got  = c;
            seen = 1'b1;
         end
      end
      check("timeout_cycles", got, TO + 1);
      check("timeout_error", int'(o_error), 1);
      check("timeout_opcode_held", int'(o_opcode), 2);
      check("timeout_busy", int'(o_busy), 0);
      check("timeout_phase", int'(o_phase), 3);
      hold_kind = -1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("error_sticky", int'(o_error), 1);
      push_frame();
      i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      @(negedge clk);
      check("restart_error_cleared", int'(o_error), 0);
      check("restart_cam", int'(o_startCam), 1);

      // Synchronous reset while waiting on the last conv1 write-back
      wait_ev("reset_point", K_WB, N0 + N1 - 1, 2000);
      @(negedge clk);
      i_reset = 1'b1;
      @(posedge clk); #1 i_reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle("mid_reset");
      repeat (8) @(negedge clk);
      check("post_reset_busy", int'(o_busy), 0);
      check("post_reset_opcode", int'(o_opcode), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
